// File: rtl/maq_ctrl_if.sv
// Button, wrap-flag and enable signals between the timekeeping controller
// and its surroundings. The slave side is the controller.
interface maq_ctrl_if;
  logic       maq_ctrl_btn_mode;
  logic       maq_ctrl_btn_inc;
  logic       maq_ctrl_sec_wrap;
  logic       maq_ctrl_min_wrap;
  logic       maq_ctrl_sec_en;
  logic       maq_ctrl_min_en;
  logic       maq_ctrl_hour_en;
  logic       maq_ctrl_sec_clr;
  logic [1:0] maq_ctrl_mode;
  logic       maq_ctrl_blink;

  modport master (
    output maq_ctrl_btn_mode,
    output maq_ctrl_btn_inc,
    output maq_ctrl_sec_wrap,
    output maq_ctrl_min_wrap,
    input  maq_ctrl_sec_en,
    input  maq_ctrl_min_en,
    input  maq_ctrl_hour_en,
    input  maq_ctrl_sec_clr,
    input  maq_ctrl_mode,
    input  maq_ctrl_blink
  );

  modport slave (
    input  maq_ctrl_btn_mode,
    input  maq_ctrl_btn_inc,
    input  maq_ctrl_sec_wrap,
    input  maq_ctrl_min_wrap,
    output maq_ctrl_sec_en,
    output maq_ctrl_min_en,
    output maq_ctrl_hour_en,
    output maq_ctrl_sec_clr,
    output maq_ctrl_mode,
    output maq_ctrl_blink
  );
endinterface

// File: rtl/maq_ctrl.sv
// Digital-clock timekeeping controller: 1 s prescaler, RUN/SET_H/SET_M mode
// sequencing, cascaded count enables and a blink strobe for the field being set.
module maq_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned HALF_DIV = TICK_DIV / 2
) (
  input  logic       maq_ctrl_clock,
  input  logic       maq_ctrl_reset,
  maq_ctrl_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HalfThr = PW'(HALF_DIV);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetH    = 2'b01,
    StSetM    = 2'b10,
    StIllegal = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_hist_q, mode_hist_d;
  logic          inc_hist_q, inc_hist_d;
  logic          sec_en_q, sec_en_d;
  logic          min_en_q, min_en_d;
  logic          hour_en_q, hour_en_d;
  logic          sec_clr_q, sec_clr_d;
  logic [1:0]    mode_q, mode_d;
  logic          blink_q, blink_d;

  logic mode_press, inc_press, tick;

  // Next-state and next-output computation for the mode FSM and prescaler.
  always_comb begin
    mode_press  = bus.maq_ctrl_btn_mode & ~mode_hist_q;
    inc_press   = bus.maq_ctrl_btn_inc & ~inc_hist_q;
    tick        = (presc_q == TickMax);

    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + PW'(1);
    mode_hist_d = bus.maq_ctrl_btn_mode;
    inc_hist_d  = bus.maq_ctrl_btn_inc;
    sec_en_d    = 1'b0;
    min_en_d    = 1'b0;
    hour_en_d   = 1'b0;
    sec_clr_d   = 1'b0;

    unique case (state_q)
      StRun: begin
        sec_en_d  = tick;
        min_en_d  = tick & bus.maq_ctrl_sec_wrap;
        hour_en_d = tick & bus.maq_ctrl_sec_wrap & bus.maq_ctrl_min_wrap;
        if (mode_press) state_d = StSetH;
      end
      StSetH: begin
        // Mode wins over a simultaneous inc press.
        if (mode_press) state_d = StSetM;
        else if (inc_press) hour_en_d = 1'b1;
      end
      StSetM: begin
        if (mode_press) begin
          state_d   = StRun;
          sec_clr_d = 1'b1;
          // Restart the second so the first tick after setting is a full period.
          presc_d   = '0;
        end else if (inc_press) begin
          min_en_d = 1'b1;
        end
      end
      StIllegal: begin
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    mode_d  = (state_d == StIllegal) ? 2'b00 : state_d;
    // Blink tracks the prescaler value that will be held alongside it.
    blink_d = ((state_d == StSetH) || (state_d == StSetM)) && (presc_d < HalfThr);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge maq_ctrl_clock) begin
    if (!maq_ctrl_reset) begin
      state_q     <= StRun;
      presc_q     <= '0;
      mode_hist_q <= 1'b1;
      inc_hist_q  <= 1'b1;
      sec_en_q    <= 1'b0;
      min_en_q    <= 1'b0;
      hour_en_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
      mode_q      <= 2'b00;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      mode_hist_q <= mode_hist_d;
      inc_hist_q  <= inc_hist_d;
      sec_en_q    <= sec_en_d;
      min_en_q    <= min_en_d;
      hour_en_q   <= hour_en_d;
      sec_clr_q   <= sec_clr_d;
      mode_q      <= mode_d;
      blink_q     <= blink_d;
    end
  end

  assign bus.maq_ctrl_sec_en  = sec_en_q;
  assign bus.maq_ctrl_min_en  = min_en_q;
  assign bus.maq_ctrl_hour_en = hour_en_q;
  assign bus.maq_ctrl_sec_clr = sec_clr_q;
  assign bus.maq_ctrl_mode    = mode_q;
  assign bus.maq_ctrl_blink   = blink_q;

endmodule

// File: tb/tb_maq_ctrl.sv
// Bench for maq_ctrl: directed scenarios then random buttons/wraps/resets,
// every cycle compared against a behavioural model of the controller.
module tb_maq_ctrl;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned HalfDiv = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maq_ctrl_if bus ();

  maq_ctrl #(
    .TICK_DIV (TickDiv),
    .HALF_DIV (HalfDiv)
  ) dut (
    .maq_ctrl_clock (clk),
    .maq_ctrl_reset (rst_n),
    .bus            (bus.slave)
  );

  int n_checks = 0;
  int n_pass = 0;
  int hour_pulses = 0;
  int min_pulses = 0;

  // Reference model: mode as 0=RUN 1=SET_H 2=SET_M, a seconds phase counter,
  // and the previously seen button levels.
  int m_mode = 0;
  int m_cnt = 0;
  bit m_hm = 1'b1;
  bit m_hi = 1'b1;
  bit e_sec, e_min, e_hour, e_clr, e_blink;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input bit rst, input bit bm, input bit bi, input bit sw,
                            input bit mw);
    bit mp, ip, tk;
    int nxt;
    e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0; e_blink = 0;
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_hm = 1; m_hi = 1;
      return;
    end
    mp  = bm && !m_hm;
    ip  = bi && !m_hi;
    tk  = (m_cnt == TickDiv - 1);
    nxt = (m_cnt + 1) % TickDiv;
    if (m_mode == 0) begin
      e_sec  = tk;
      e_min  = tk && sw;
      e_hour = tk && sw && mw;
      if (mp) m_mode = 1;
    end else if (m_mode == 1) begin
      if (mp) m_mode = 2;
      else if (ip) e_hour = 1;
    end else begin
      if (mp) begin
        m_mode = 0; e_clr = 1; nxt = 0;
      end else if (ip) begin
        e_min = 1;
      end
    end
    m_cnt   = nxt;
    m_hm    = bm;
    m_hi    = bi;
    e_blink = (m_mode != 0) && (m_cnt < HalfDiv);
  endtask

  // One clock: drive inputs, update model at the edge, compare on the falling edge.
  task automatic step(input bit bm, input bit bi, input bit sw, input bit mw);
    bus.maq_ctrl_btn_mode = bm;
    bus.maq_ctrl_btn_inc  = bi;
    bus.maq_ctrl_sec_wrap = sw;
    bus.maq_ctrl_min_wrap = mw;
    @(posedge clk);
    model_edge(rst_n, bm, bi, sw, mw);
    @(negedge clk);
    check("sec_en", bus.maq_ctrl_sec_en, e_sec);
    check("min_en", bus.maq_ctrl_min_en, e_min);
    check("hour_en", bus.maq_ctrl_hour_en, e_hour);
    check("sec_clr", bus.maq_ctrl_sec_clr, e_clr);
    check("mode", bus.maq_ctrl_mode, m_mode);
    check("blink", bus.maq_ctrl_blink, e_blink);
    if (bus.maq_ctrl_hour_en === 1'b1) hour_pulses++;
    if (bus.maq_ctrl_min_en === 1'b1) min_pulses++;
  endtask

  initial begin
    bit bm_r, bi_r;
    bm_r = 0;
    bi_r = 0;

    // Reset held, then free-running RUN with buttons low.
    rst_n = 1'b0;
    repeat (3) step(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (8) step(0, 0, 0, 0);

    // Cascaded carries across ticks.
    repeat (4) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 1);

    // SET_H with three separate inc presses.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    hour_pulses = 0;
    min_pulses  = 0;
    repeat (3) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    repeat (4) step(0, 0, 0, 0);
    check("set_h_hour_pulses", hour_pulses, 3);
    check("set_h_min_pulses", min_pulses, 0);

    // SET_M inc with min_wrap high, then back to RUN.
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    hour_pulses = 0;
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    check("set_m_no_carry", hour_pulses, 0);
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // Simultaneous mode and inc in SET_H, then held inc in SET_M.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    hour_pulses = 0;
    step(1, 1, 0, 0);
    check("sim_press_mode", bus.maq_ctrl_mode, 2);
    step(0, 0, 0, 0);
    check("sim_press_no_hour", hour_pulses, 0);
    min_pulses = 0;
    repeat (10) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("held_inc_single", min_pulses, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Mode button held through reset release.
    rst_n = 1'b0;
    repeat (2) step(1, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) step(1, 0, 0, 0);
    check("held_mode_stays_run", bus.maq_ctrl_mode, 0);
    step(0, 0, 0, 0);

    // Reset while in SET_M with an inc press arriving at the same edge.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 1, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Random buttons, wraps and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bm_r = ~bm_r;
      if ($urandom_range(0, 3) == 0) bi_r = ~bi_r;
      rst_n = ($urandom_range(0, 79) != 0);
      step(bm_r, bi_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
